alu_result_fifo: RTL

Downstream capture stage for the 3-bit ALU. Each cycle the ALU result {R, CF, SF, ZF} is offered with a valid strobe. This block buffers accepted results in a small first-word-fall-through FIFO and hands them to the consumer over a valid/ready handshake. It also keeps sticky carry/zero flags and a saturating count of accepted results for status readback.

---
 rtl/alu_result_fifo_if.sv | 48 ++++
 rtl/alu_result_fifo.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if
//   Bundles the ALU-result capture signals of alu_result_fifo.
//   slave  : the FIFO view (takes the ALU result and out_ready/clr_stats;
//            drives in_ready, the head entry and the status counters).
//   master : the view of whoever drives the ALU side and consumes entries.
//   Signals:
//     in_valid/in_ready, in_r, in_cf/in_sf/in_zf   producer handshake + data
//     out_valid/out_ready, out_r, out_cf/sf/zf     consumer handshake + data
//     count                                        occupancy
//     sticky_cf, sticky_zf, res_cnt, clr_stats     status readback / clear
interface alu_result_fifo_if #(
  parameter int DEPTH = 4,
  parameter int W     = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_r;
  logic          in_cf;
  logic          in_sf;
  logic          in_zf;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_r;
  logic          out_cf;
  logic          out_sf;
  logic          out_zf;

  logic [CW-1:0] count;
  logic          sticky_cf;
  logic          sticky_zf;
  logic [7:0]    res_cnt;
  logic          clr_stats;

  modport slave (
    input  in_valid, in_r, in_cf, in_sf, in_zf, out_ready, clr_stats,
    output in_ready, out_valid, out_r, out_cf, out_sf, out_zf,
           count, sticky_cf, sticky_zf, res_cnt
  );

  modport master (
    output in_valid, in_r, in_cf, in_sf, in_zf, out_ready, clr_stats,
    input  in_ready, out_valid, out_r, out_cf, out_sf, out_zf,
           count, sticky_cf, sticky_zf, res_cnt
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Capture stage behind the 3-bit ALU. Accepted results {R, CF, SF, ZF}
//   are held in a DEPTH-entry first-word-fall-through FIFO and handed to
//   the consumer over valid/ready. Sticky carry/zero flags and a saturating
//   8-bit count of accepted results are kept for status readback.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears pointers, count,
//            statistics and the storage array)
//     bus    alu_result_fifo_if.slave, all handshake, data and status
//   DEPTH must be a power of two and at least 2 so the pointers wrap
//   naturally modulo DEPTH.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_result_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = W + 3;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Stored entry layout: {r, cf, sf, zf}
  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          sticky_cf_q, sticky_cf_d;
  logic          sticky_zf_q, sticky_zf_d;
  logic [7:0]    res_cnt_q,   res_cnt_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- handshake decode (registered state only) ----
  // in_ready comes from count_q alone, so a pop in a full cycle does not
  // reopen the input until the following cycle.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push     = bus.in_valid  && !full;
  assign pop      = bus.out_ready && !empty;
  assign wr_entry = {bus.in_r, bus.in_cf, bus.in_sf, bus.in_zf};

  // ---- next-state ----
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A clear coincident with a push acts first, so the push lands on
  // freshly cleared statistics.
  always_comb begin
    sticky_cf_d = bus.clr_stats ? 1'b0 : sticky_cf_q;
    sticky_zf_d = bus.clr_stats ? 1'b0 : sticky_zf_q;
    res_cnt_d   = bus.clr_stats ? 8'd0 : res_cnt_q;

    if (push) begin
      sticky_cf_d = sticky_cf_d | bus.in_cf;
      sticky_zf_d = sticky_zf_d | bus.in_zf;
      res_cnt_d   = sat_inc8(res_cnt_d);
    end
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sticky_cf_q <= 1'b0;
      sticky_zf_q <= 1'b0;
      res_cnt_q   <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sticky_cf_q <= sticky_cf_d;
      sticky_zf_q <= sticky_zf_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // ---- storage array ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ---- output view ----
  // First-word-fall-through: the head is read combinationally, and is
  // masked to zero while the FIFO holds nothing.
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_r     = head[EW-1:3];
  assign bus.out_cf    = head[2];
  assign bus.out_sf    = head[1];
  assign bus.out_zf    = head[0];
  assign bus.count     = count_q;
  assign bus.sticky_cf = sticky_cf_q;
  assign bus.sticky_zf = sticky_zf_q;
  assign bus.res_cnt   = res_cnt_q;

endmodule
